iic_seq_ctrl: RTL and testbench
===============================

IIC_SEQ_CTRL -- requirements
Module: iic_seq_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4: command-table entries, legal range 1..16.
REQ-002 SHALL have parameter TICK_DIV, default 100000000: clk cycles per tick in loop mode, at least 2.
REQ-003 SHALL have parameter DEV_ADDR, default 7'h38: 7-bit I2C slave address driven on iic_dev_addr.
REQ-004 SHALL have parameter TIMEOUT, default 1000000: maximum clk cycles to wait for iic_done.
REQ-005 SHALL define AW = max(1, clog2(DEPTH)).
REQ-006 SHALL have ports, clock and reset first:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  AW  table entry to write.
- cfg_w  in  1  entry type: 1 = write, 0 = read.
- cfg_reg  in  8  entry register address.
- cfg_data  in  8  entry write data.
- cfg_len  in  AW+1  number of active entries.
- mode_loop  in  1  1 = periodic looping, 0 = one-shot.
- run  in  1  loop-mode enable.
- trig  in  1  one-shot start pulse.
- iic_start  out  1  one-cycle transaction request to iic_master.
- iic_dev_addr  out  7  device address.
- iic_reg_addr  out  8  register address.
- iic_w  out  1  transaction type.
- iic_wd  out  8  write data.
- iic_rdata  in  8  read data from iic_master.
- iic_done  in  1  one-cycle transaction-complete pulse.
- busy  out  1  high whenever state is not IDLE.
- seq_done  out  1  one-cycle pulse at the end of a one-shot pass.
- rd_valid  out  1  one-cycle pulse when a read entry completes.
- rd_idx  out  AW  index of the completed read entry.
- rd_data  out  8  captured read byte.
- err  out  1  sticky timeout flag.

Function
REQ-007 SHALL hold a DEPTH-entry table of {w, reg[7:0], data[7:0]}; on cfg_we=1, cfg_idx<DEPTH, write the entry at the next clk; cfg_idx>=DEPTH SHALL be ignored.
REQ-008 SHALL sample cfg_len only on entry to RUN; the effective length is min(cfg_len, DEPTH); a length of 0 SHALL block all starts.
REQ-009 SHALL use states IDLE, WAIT_TICK, ISSUE, WAIT_DONE, NEXT.
REQ-010 Tick counter: counts 0..TICK_DIV-1 only when en=1; tick is asserted on the wrap; the counter is cleared on entry to WAIT_TICK.
REQ-011 IDLE -> WAIT_TICK when mode_loop=1, run=1, en=1, length>0; idx set to 0.
REQ-012 IDLE -> ISSUE when mode_loop=0, trig=1, en=1, length>0; idx set to 0; trig SHALL be ignored in any state other than IDLE.
REQ-013 WAIT_TICK -> ISSUE on tick; -> IDLE if run=0 or mode_loop=0.
REQ-014 ISSUE: load iic_reg_addr, iic_w, iic_wd from table[idx]; pulse iic_start for exactly one cycle; -> WAIT_DONE.
REQ-015 iic_* fields SHALL stay stable from ISSUE until iic_done; table writes during this window SHALL NOT alter them.
REQ-016 WAIT_DONE: on iic_done -> NEXT; if entry w=0, latch rd_data=iic_rdata and rd_idx=idx, and pulse rd_valid in the same cycle.
REQ-017 WAIT_DONE timeout: after TIMEOUT cycles with no iic_done, set err=1 and go to IDLE; no rd_valid and no seq_done.
REQ-018 NEXT, one-shot: if idx==length-1, pulse seq_done and go to IDLE; else idx+1 and go to ISSUE, so entries run back-to-back.
REQ-019 NEXT, loop: idx wraps from length-1 to 0, else idx+1; go to WAIT_TICK, so one entry is issued per tick.
REQ-020 en=0 SHALL freeze the tick counter and block IDLE exits and ISSUE entry; an in-flight WAIT_DONE SHALL still complete or time out.
REQ-021 run deasserted mid-transaction SHALL let the current transaction complete; exit happens from WAIT_TICK.
REQ-022 iic_done outside WAIT_DONE SHALL be ignored.
REQ-023 err SHALL clear only on reset or on the next accepted start (REQ-011/REQ-012).
REQ-024 iic_dev_addr SHALL be constant DEV_ADDR.

Reset
REQ-025 rst=1 at a clk edge SHALL force: state IDLE, idx 0, tick counter 0, iic_start 0, iic_reg_addr 0, iic_w 0, iic_wd 0, busy 0, seq_done 0, rd_valid 0, rd_idx 0, rd_data 0, err 0.
REQ-026 Table contents SHALL be unchanged by reset.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no further pulses on any output.

Verification
REQ-028 Loop, TICK_DIV=10, table {W,01,DF},{W,01,BF},{W,01,7F},{W,03,1F}, len=4, done returned 3 cycles after start -> iic_start every 10+ cycles, reg/data in that order, then wraps to entry 0.
REQ-029 One-shot, len=3 with entry 1 a read, iic_rdata=A5 -> three back-to-back starts; one rd_valid with rd_idx=1 and rd_data=A5; seq_done one cycle after the last done; busy falls the cycle after that.
REQ-030 iic_done withheld, TIMEOUT=20 -> err=1 at cycle 20 of WAIT_DONE, state IDLE; next trig clears err.
REQ-031 cfg_len=0 or en=0, then trig -> no iic_start, busy stays 0; cfg_idx=DEPTH write leaves the table unchanged.
REQ-032 rst pulsed during WAIT_DONE, then a late iic_done -> every output at its reset value, no rd_valid or seq_done.

Source files
------------

// File: rtl/iic_seq_ctrl.sv
// iic_seq_ctrl: table-driven I2C transaction sequencer, one-shot or tick-paced loop
// Ports: clk/rst (sync, active-high); en global enable; cfg_* table write and length;
//   mode_loop/run/trig pass control; iic_* request/response to the I2C master;
//   busy, seq_done, rd_valid/rd_idx/rd_data, err (sticky timeout) status.
module iic_seq_ctrl #(
  parameter int DEPTH = 4,
  parameter int TICK_DIV = 100000000,
  parameter logic [6:0] DEV_ADDR = 7'h38,
  parameter int TIMEOUT = 1000000,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_idx,
  input  logic          cfg_w,
  input  logic [7:0]    cfg_reg,
  input  logic [7:0]    cfg_data,
  input  logic [AW:0]   cfg_len,
  input  logic          mode_loop,
  input  logic          run,
  input  logic          trig,
  output logic          iic_start,
  output logic [6:0]    iic_dev_addr,
  output logic [7:0]    iic_reg_addr,
  output logic          iic_w,
  output logic [7:0]    iic_wd,
  input  logic [7:0]    iic_rdata,
  input  logic          iic_done,
  output logic          busy,
  output logic          seq_done,
  output logic          rd_valid,
  output logic [AW-1:0] rd_idx,
  output logic [7:0]    rd_data,
  output logic          err
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int OW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] DL = (AW+1)'(DEPTH);
  typedef enum logic [2:0] {IDLE, WAIT_TICK, ISSUE, WAIT_DONE, NEXT} state_t;
  state_t state;
  logic tw [DEPTH];
  logic [7:0] treg [DEPTH];
  logic [7:0] tdat [DEPTH];
  logic [AW-1:0] idx;
  logic [AW:0] len;
  logic loop;
  logic [TW-1:0] tcnt;
  logic [OW-1:0] ocnt;
  logic [AW:0] eff_len;
  logic tick, last;
  assign eff_len = cfg_len > DL ? DL : cfg_len;
  assign tick = en && tcnt == TW'(TICK_DIV - 1);
  assign last = {1'b0, idx} == len - 1'b1;
  assign busy = state != IDLE;
  assign iic_dev_addr = DEV_ADDR;
  // table has no reset so its contents survive rst
  always_ff @(posedge clk)
    if (cfg_we && {1'b0, cfg_idx} < DL) begin
      tw[cfg_idx] <= cfg_w;
      treg[cfg_idx] <= cfg_reg;
      tdat[cfg_idx] <= cfg_data;
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      len <= '0;
      loop <= 1'b0;
      tcnt <= '0;
      ocnt <= '0;
      iic_start <= 1'b0;
      iic_reg_addr <= '0;
      iic_w <= 1'b0;
      iic_wd <= '0;
      seq_done <= 1'b0;
      rd_valid <= 1'b0;
      rd_idx <= '0;
      rd_data <= '0;
      err <= 1'b0;
    end else begin
      iic_start <= 1'b0;
      seq_done <= 1'b0;
      rd_valid <= 1'b0;
      if (en) tcnt <= tick ? '0 : tcnt + 1'b1;
      case (state)
        IDLE:
          if (en && eff_len != '0 && (mode_loop ? run : trig)) begin
            idx <= '0;
            len <= eff_len;
            loop <= mode_loop;
            err <= 1'b0;
            tcnt <= '0;
            state <= mode_loop ? WAIT_TICK : ISSUE;
          end
        WAIT_TICK:
          if (!run || !mode_loop) state <= IDLE;
          else if (tick) state <= ISSUE;
        ISSUE: begin
          iic_start <= 1'b1;
          iic_reg_addr <= treg[idx];
          iic_w <= tw[idx];
          iic_wd <= tdat[idx];
          ocnt <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE:
          if (iic_done) begin
            rd_valid <= !iic_w;
            if (!iic_w) begin
              rd_idx <= idx;
              rd_data <= iic_rdata;
            end
            // end-of-pass pulse lands one cycle after the final done
            seq_done <= !loop && last;
            state <= NEXT;
          end else if (ocnt == OW'(TIMEOUT - 1)) begin
            err <= 1'b1;
            state <= IDLE;
          end else ocnt <= ocnt + 1'b1;
        NEXT:
          if (loop) begin
            idx <= last ? '0 : idx + 1'b1;
            tcnt <= '0;
            state <= WAIT_TICK;
          end else if (last) state <= IDLE;
          else if (en) begin
            idx <= idx + 1'b1;
            state <= ISSUE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_iic_seq_ctrl.sv
// tb_iic_seq_ctrl: randomized self-checking bench for iic_seq_ctrl against a table model
module tb_iic_seq_ctrl;
  localparam int DEPTH = 3;
  localparam int AW = 2;
  localparam int TD = 10;
  localparam int TO = 20;
  logic clk = 0, rst = 1, en = 0, cfg_we = 0, cfg_w = 0;
  logic [AW-1:0] cfg_idx = '0;
  logic [7:0] cfg_reg = '0, cfg_data = '0, iic_rdata = '0;
  logic [AW:0] cfg_len = '0;
  logic mode_loop = 0, run = 0, trig = 0, iic_done = 0;
  logic iic_start, iic_w, busy, seq_done, rd_valid, err;
  logic [6:0] iic_dev_addr;
  logic [7:0] iic_reg_addr, iic_wd, rd_data;
  logic [AW-1:0] rd_idx;
  int total = 0, bad = 0, cyc = 0;
  logic mw [DEPTH];
  logic [7:0] mreg [DEPTH], mdat [DEPTH];
  iic_seq_ctrl #(.DEPTH(DEPTH), .TICK_DIV(TD), .DEV_ADDR(7'h38), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_w(cfg_w),
    .cfg_reg(cfg_reg), .cfg_data(cfg_data), .cfg_len(cfg_len), .mode_loop(mode_loop),
    .run(run), .trig(trig), .iic_start(iic_start), .iic_dev_addr(iic_dev_addr),
    .iic_reg_addr(iic_reg_addr), .iic_w(iic_w), .iic_wd(iic_wd), .iic_rdata(iic_rdata),
    .iic_done(iic_done), .busy(busy), .seq_done(seq_done), .rd_valid(rd_valid),
    .rd_idx(rd_idx), .rd_data(rd_data), .err(err));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int i, input logic w, input logic [7:0] r, input logic [7:0] d);
    cfg_we = 1; cfg_idx = AW'(i); cfg_w = w; cfg_reg = r; cfg_data = d;
    step();
    cfg_we = 0;
    if (i < DEPTH) begin
      mw[i] = w; mreg[i] = r; mdat[i] = d;
    end
  endtask
  task automatic wait_start(output int n);
    n = 0;
    while (!iic_start && n < 60) begin
      step();
      n++;
    end
    chk("start_seen", iic_start, 1);
  endtask
  // responds to the transaction in flight for entry k; may rewrite that entry meanwhile
  task automatic serve(input int k, input bit last_os);
    logic ow;
    logic [7:0] oreg, odat, rd;
    int d;
    ow = mw[k]; oreg = mreg[k]; odat = mdat[k];
    chk("reg", iic_reg_addr, oreg);
    chk("w", iic_w, ow);
    chk("wd", iic_wd, odat);
    chk("dev", iic_dev_addr, 7'h38);
    chk("busy_run", busy, 1);
    d = $urandom_range(0, 3);
    if (d > 0) begin
      wr(k, 1'($urandom), 8'($urandom), 8'($urandom));
      repeat (d - 1) step();
      chk("reg_hold", iic_reg_addr, oreg);
      chk("wd_hold", {iic_w, iic_wd}, {ow, odat});
    end
    rd = 8'($urandom);
    iic_rdata = rd; iic_done = 1;
    step();
    iic_done = 0;
    chk("rd_valid", rd_valid, !ow);
    if (!ow) begin
      chk("rd_idx", rd_idx, k);
      chk("rd_data", rd_data, rd);
    end
    chk("seq_done", seq_done, last_os);
  endtask
  task automatic oneshot(input int lc);
    int n, g;
    n = lc < DEPTH ? lc : DEPTH;
    cfg_len = (AW+1)'(lc); mode_loop = 0; trig = 1;
    step();
    trig = 0;
    for (int k = 0; k < n; k++) begin
      wait_start(g);
      chk(k == 0 ? "lat" : "gap", g, k == 0 ? 1 : 2);
      chk("err_clr", err, 0);
      serve(k, k == n - 1);
    end
    step();
    chk("busy_end", busy, 0);
    chk("seq_once", seq_done, 0);
  endtask
  task automatic loop_run(input int lc, input int ns);
    int n, g, prev;
    n = lc < DEPTH ? lc : DEPTH;
    cfg_len = (AW+1)'(lc); mode_loop = 1; run = 1;
    prev = 0;
    for (int s = 0; s < ns; s++) begin
      wait_start(g);
      if (s > 0) chk("period", cyc - prev >= TD, 1);
      prev = cyc;
      if (s == ns - 1) run = 0;
      serve(s % n, 0);
    end
    g = 0;
    while (busy && g < 40) begin
      step();
      g++;
    end
    chk("loop_stop", busy, 0);
    g = 0;
    repeat (30) begin
      step();
      g += int'(iic_start);
    end
    chk("loop_quiet", g, 0);
    mode_loop = 0;
  endtask
  task automatic blocked(input string tag);
    int s;
    s = 0;
    trig = 1; run = 1;
    repeat (25) begin
      step();
      s += int'(iic_start) + int'(busy);
    end
    trig = 0; run = 0;
    chk(tag, s, 0);
  endtask
  initial begin
    int g;
    repeat (2) step();
    chk("rst_out", {iic_start, iic_reg_addr, iic_w, iic_wd, busy, seq_done, rd_valid}, 0);
    chk("rst_rd", {rd_idx, rd_data, err}, 0);
    rst = 0; en = 1;
    for (int i = 0; i < DEPTH; i++) wr(i, 1'($urandom), 8'($urandom), 8'($urandom));
    wr(DEPTH, 1'($urandom), 8'($urandom), 8'($urandom));
    for (int t = 0; t < 6; t++) oneshot($urandom_range(1, 7));
    for (int t = 0; t < 2; t++) loop_run($urandom_range(1, 4), 5);
    cfg_len = 0;
    blocked("len0");
    mode_loop = 1;
    blocked("len0_loop");
    mode_loop = 0; cfg_len = 3; en = 0;
    blocked("en0");
    en = 1;
    cfg_len = 1; trig = 1;
    step();
    trig = 0;
    wait_start(g);
    repeat (TO - 1) step();
    chk("err_early", err, 0);
    step();
    chk("err_set", {err, busy}, 2'b10);
    iic_done = 1;
    step();
    iic_done = 0;
    chk("late_done", {rd_valid, seq_done, err}, 3'b001);
    oneshot(3);
    cfg_len = 3; trig = 1;
    step();
    trig = 0;
    wait_start(g);
    step();
    rst = 1;
    step();
    rst = 0; iic_done = 1;
    step();
    iic_done = 0;
    chk("mid_rst", {iic_start, iic_reg_addr, iic_w, iic_wd, busy, seq_done, rd_valid}, 0);
    chk("mid_rst_rd", {rd_idx, rd_data, err}, 0);
    g = 0;
    repeat (5) begin
      step();
      g += int'(rd_valid) + int'(seq_done) + int'(busy) + int'(iic_start);
    end
    chk("rst_quiet", g, 0);
    oneshot(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
